// File: rtl/ddfs_phase_gen.sv
// ddfs_phase_gen
// Phase accumulator and ROM address generator for the DDFS datapath.
// It advances a PHASE_WIDTH-bit accumulator once every div+1 clocks.
// Each sample is the pre-increment phase, truncated to ADDR_WIDTH bits
// with a phase offset added. The result feeds a sine ROM with a
// registered read. The run/stop FSM only returns to IDLE on an
// accumulator wrap, so the output waveform never stops mid-cycle.
//
// Optional build macro: DDFS_DITHER_EN
//   When defined, a 16-bit LFSR adds dither below the truncation point
//   for address generation only.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       run request (level)
//   stop        graceful stop request (honoured at the next phase wrap)
//   fcw         frequency control word
//   fcw_load    capture fcw into the internal register
//   pha         phase offset added to the ROM address
//   div         sample period minus 1, in clk cycles
//   r_addr      ROM read address
//   addr_valid  1-cycle pulse when r_addr updates
//   data_valid  addr_valid delayed by the ROM read latency (1 cycle)
//   wrap        1-cycle pulse: accumulator overflowed on this sample
//   busy        FSM is not IDLE
module ddfs_phase_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] fcw,
    input  logic                   fcw_load,
    input  logic [ADDR_WIDTH-1:0]  pha,
    input  logic [DIV_WIDTH-1:0]   div,
    output logic [ADDR_WIDTH-1:0]  r_addr,
    output logic                   addr_valid,
    output logic                   data_valid,
    output logic                   wrap,
    output logic                   busy
);

    localparam int PW = PHASE_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_fcw;
    logic [DW-1:0]   r_cnt;
    logic            r_addrValid;
    logic            r_dataValid;
    logic            r_wrap;

    logic            w_tick;
    logic [PW:0]     w_sum;
    logic            w_carry;
    logic [AW-1:0]   w_addrBase;

    // A sample tick fires when the divider count reaches div.
    // No ticks happen while idle.
    assign w_tick  = (r_state != IDLE) && (r_cnt == div);

    // One extra bit on the sum captures the accumulator carry.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_fcw};
    assign w_carry = w_sum[PW];

`ifdef DDFS_DITHER_EN
    localparam int DITH_W = ((PW - AW) < 16) ? (PW - AW) : 16;

    logic [15:0]   r_lfsr;
    logic          w_lfsrFb;
    logic [PW-1:0] w_dithAcc;

    // Fibonacci LFSR with taps 16,14,13,11.
    assign w_lfsrFb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Dither goes only into the address path, never back into the accumulator.
    assign w_dithAcc  = r_acc + PW'(r_lfsr[DITH_W-1:0]);
    assign w_addrBase = w_dithAcc[PW-1 -: AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_tick) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
        end
    end
`else
    assign w_addrBase = r_acc[PW-1 -: AW];
`endif

    // Run/stop FSM. busy is registered alongside the state.
    // start wins over stop. DRAIN returns to IDLE only on a tick that
    // wraps the accumulator, or on any tick when fcw is zero (it would
    // never wrap).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop && !start) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (start) begin
                        r_state <= RUN;
                    end else if (w_tick && (w_carry || (r_fcw == '0))) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: fcw capture, divider, accumulator, address and strobes.
    // The emitted address uses the pre-increment accumulator. The
    // accumulator and divider are held at zero while idle, so every run
    // starts from phase 0 with a full sample period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcw       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_addrValid <= 1'b0;
            r_dataValid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            if (fcw_load) begin
                r_fcw <= fcw;
            end
            r_dataValid <= r_addrValid;
            r_addrValid <= w_tick;
            r_wrap      <= w_tick & w_carry;
            if (r_state == IDLE) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_tick ? '0 : (r_cnt + DW'(1));
                if (w_tick) begin
                    r_acc  <= w_sum[PW-1:0];
                    r_addr <= w_addrBase + pha;
                end
            end
        end
    end

    assign addr_valid = r_addrValid;
    assign data_valid = r_dataValid;
    assign wrap       = r_wrap;
    assign busy       = r_busy;

endmodule

// File: doc/ddfs_phase_gen.md
# ddfs_phase_gen

Phase accumulator and address generator for the DDFS datapath. It sits directly upstream of the sine lookup ROM, which has a 2048-entry table and a registered read. The block advances an N-bit phase accumulator at a programmable sample rate and truncates it to a ROM address with a phase offset applied. It issues a valid strobe aligned to the ROM's 1-cycle read latency, and its run/stop FSM stops only at a phase wrap, so the output never clicks mid-cycle.

## Interface
- PHASE_WIDTH, 32, accumulator width
- ADDR_WIDTH, 11, ROM address width (top bits of accumulator)
- DIV_WIDTH, 16, sample-rate divider width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  run request (level sampled each cycle)
- stop  in  1  graceful stop request
- fcw  in  PHASE_WIDTH  frequency control word
- fcw_load  in  1  capture fcw into internal register
- pha  in  ADDR_WIDTH  phase offset added to address
- div  in  DIV_WIDTH  sample period minus 1 (clk cycles)
- r_addr  out  ADDR_WIDTH  ROM read address
- addr_valid  out  1  1-cycle pulse when r_addr updates
- data_valid  out  1  addr_valid delayed 1 cycle (ROM data valid)
- wrap  out  1  1-cycle pulse, accumulator overflowed this sample
- busy  out  1  state != IDLE

## Operation
- Reset: state IDLE, acc=0, fcw register=0, divider count=0, LFSR seeded; r_addr, addr_valid, data_valid, wrap, busy all 0.
- fcw register: written from fcw on any cycle with fcw_load. It is used only at ticks, so a load on cycle T affects a tick on T+1 or later.
- Divider: in IDLE held at 0. Otherwise tick = (cnt == div), and cnt wraps to 0 on tick, else increments. div=0 ticks every cycle.
- On tick:
  - r_addr <= acc[PW-1 -: AW] + pha (mod 2^AW).
  - acc <= acc + fcw (mod 2^PW).
  - addr_valid <= 1.
  - wrap <= carry out of that add.
  - The sample emitted is the pre-increment phase, so the first sample after start is pha.
- data_valid <= addr_valid every cycle.
- Outside ticks: addr_valid=0, wrap=0, r_addr holds.
- FSM:
  - IDLE: acc forced to 0. start -> RUN. stop ignored.
  - RUN: ticking. stop and !start -> DRAIN. start has priority when both are high.
  - DRAIN: ticking. start -> RUN (cancels stop). Tick with carry -> IDLE. Tick with fcw==0 -> IDLE, because it would never wrap.
- Entering IDLE from DRAIN: the final sample is still emitted with wrap=1. acc clears the following cycle, and r_addr holds its last value.
- Reset mid-operation: immediate return to reset values. Any pending data_valid is dropped.

## Timing
- start high on cycle 0 -> busy=1 on cycle 1.
- First tick on cycle 1+div; first addr_valid on cycle 2+div; first data_valid on cycle 3+div.
- Subsequent addr_valid every div+1 cycles.
- Final DRAIN tick on cycle T -> addr_valid and wrap on T+1, busy=0 on T+1; data_valid on T+2 is still produced.
- Address wrap from pha alone (2^AW-1 -> 0) does not assert wrap; wrap tracks the accumulator only.
- Changing div while running: takes effect at the next comparison. If cnt > new div, cnt counts up to 2^DIV_WIDTH-1 and wraps to 0 before ticking.

## Configuration
- DDFS_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per tick.
  - Its low min(16, PW-AW) bits are added to acc before truncation, for address generation only. The dither is never fed back into acc, and wrap is unaffected.
- DDFS_DITHER_EN undefined: plain truncation, no LFSR logic.
- Test plan expected values assume DDFS_DITHER_EN undefined.

## Test plan
- Reset held 3 cycles with start=1 -> busy, r_addr, addr_valid, data_valid, wrap all 0 throughout; busy=1 one cycle after release.
- fcw=32'h0020_0000, div=0, pha=0, start -> r_addr 0,1,2,… on consecutive cycles; wrap pulse coincides with r_addr=2047 (sample 2048); data_valid trails addr_valid by exactly 1.
- div=3, same fcw -> first addr_valid on cycle 5 after start, then every 4 cycles; r_addr increments by 1 per pulse.
- Running at step 1, fcw_load with 32'h0040_0000 one cycle before a tick -> that tick's emitted address still steps by 1 from the previous sample; every later sample steps by 2.
- stop pulsed while r_addr=100 (step 1) -> samples continue to 2047 with wrap=1, busy=0 the same cycle; a later start emits pha first.
- pha=1024, fcw=32'h0020_0000 -> r_addr 1024…2047, 0, 1… with no wrap at the address rollover; wrap at r_addr=1023. Separately, fcw=0 in DRAIN -> IDLE after one tick.
